alu_seq_ctrl: RTL

Multi-cycle sequencer that runs unsigned 32-bit multiply (low word) and unsigned 32-bit divide (quotient and remainder) using the existing 3-bit-op combinational ALU.
- Issues exactly one ALU operation per cycle: add, shift-left, slt or sub.
- The ALU stays outside the block, so the CPU datapath can share it while `busy` is low.
- Accepts a start pulse and returns results with a one-cycle `done` pulse.

---
 rtl/alu_seq_ctrl_pkg.sv | 22 ++
 rtl/alu.sv | 33 +++
 rtl/alu_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared ALU opcode constants and the sequencer state encoding.
package alu_seq_ctrl_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StMulAdd,
        StMulShl,
        StDivCmp,
        StDivSub,
        StDone
    } state_e;

endpackage

// File: rtl/alu.sv
// Existing 3-bit-op combinational ALU shared with the CPU datapath.
module alu
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] y_o
);

    localparam int unsigned ShW = $clog2(WIDTH);

    logic [ShW-1:0] shamt;
    assign shamt = b_i[ShW-1:0];

    always_comb begin
        y_o = '0;
        unique case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_SLT: y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_SRL: y_o = a_i >> shamt;
            ALU_SLL: y_o = a_i << shamt;
            ALU_OR:  y_o = a_i | b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle unsigned multiply / divide sequencer driving an external shared ALU,
// one ALU operation per cycle (shift-add multiply, restoring divide).
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             lt_q, lt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;

    logic             last_iter;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] rem_next;

    assign last_iter = (cnt_q == {CNT_W{1'b1}});
    assign rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    // A bit shifted out of rem means the partial remainder exceeds 2^WIDTH, so always subtract.
    assign rem_next  = lt_q ? rem_q : alu_out;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        lt_d     = lt_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = ALU_ADD;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = '0;
                    if (!op_div) begin
                        acc_d    = '0;
                        mcand_d  = src_a;
                        mplier_d = src_b;
                        state_d  = StMulAdd;
                    end else if (src_b != '0) begin
                        rem_d   = '0;
                        quo_d   = src_a;
                        div_d   = src_b;
                        state_d = StDivCmp;
                    end else begin
                        res_lo_d = '1;
                        res_hi_d = src_a;
                        state_d  = StDone;
                    end
                end
            end
            StMulAdd: begin
                alu_a   = acc_q;
                alu_b   = mplier_q[0] ? mcand_q : '0;
                alu_op  = ALU_ADD;
                acc_d   = alu_out;
                state_d = StMulShl;
            end
            StMulShl: begin
                alu_a    = mcand_q;
                alu_b    = WIDTH'(1);
                alu_op   = ALU_SLL;
                mcand_d  = alu_out;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    res_lo_d = acc_q;
                    res_hi_d = '0;
                    state_d  = StDone;
                end else begin
                    state_d = StMulAdd;
                end
            end
            StDivCmp: begin
                alu_a   = rem_shift;
                alu_b   = div_q;
                alu_op  = ALU_SLT;
                lt_d    = alu_out[0] & ~rem_q[WIDTH-1];
                rem_d   = rem_shift;
                quo_d   = quo_q << 1;
                state_d = StDivSub;
            end
            StDivSub: begin
                alu_a  = rem_q;
                alu_b  = div_q;
                alu_op = ALU_SUB;
                rem_d  = rem_next;
                quo_d  = {quo_q[WIDTH-1:1], quo_q[0] | ~lt_q};
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    res_lo_d = {quo_q[WIDTH-1:1], quo_q[0] | ~lt_q};
                    res_hi_d = rem_next;
                    state_d  = StDone;
                end else begin
                    state_d = StDivCmp;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            lt_q     <= 1'b0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            lt_q     <= lt_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

endmodule
